// File: rtl/dm_cache_tag_ctrl.sv
// Arbiter and sweep sequencer that owns the single port of a direct-mapped tag store.
// Entries are {valid, dirty, tag}; a sweep clears every entry, and invalidate sweeps also count destroyed dirty lines.
module dm_cache_tag_ctrl #(
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctl_valid,
  input  logic               ctl_we,
  input  logic [INDEX_W-1:0] ctl_index,
  input  logic [TAG_W+1:0]   ctl_wtag,
  output logic               ctl_ready,
  output logic [TAG_W+1:0]   ctl_rtag,
  input  logic               inv_req,
  output logic               inv_busy,
  output logic               inv_done,
  output logic [INDEX_W:0]   dirty_cnt,
  output logic               mem_we,
  output logic [INDEX_W-1:0] mem_index,
  output logic [TAG_W+1:0]   mem_wtag,
  input  logic [TAG_W+1:0]   mem_rtag
);

  localparam int VALID_BIT = TAG_W + 1;
  localparam int DIRTY_BIT = TAG_W;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [INDEX_W:0]   dirty_cnt_q, dirty_cnt_d;
  logic               inv_done_q, inv_done_d;
  logic               last_entry;
  logic               rd_dirty_line;

  assign last_entry    = (ptr_q == {INDEX_W{1'b1}});
  assign rd_dirty_line = mem_rtag[VALID_BIT] & mem_rtag[DIRTY_BIT];

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dirty_cnt_d = dirty_cnt_q;
    inv_done_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (last_entry) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (inv_req) begin
          state_d     = ST_SWEEP;
          ptr_d       = '0;
          dirty_cnt_d = '0;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        // The read is combinational, so the entry is inspected before this cycle's clearing write lands.
        if (rd_dirty_line) dirty_cnt_d = dirty_cnt_q + 1'b1;
        if (last_entry) begin
          state_d    = ST_IDLE;
          inv_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Port mux: the sweep engine owns the store outside IDLE; reset forces the port quiet.
  always_comb begin
    mem_we    = 1'b0;
    mem_index = ptr_q;
    mem_wtag  = '0;
    ctl_ready = 1'b0;
    inv_busy  = 1'b1;
    if (!rst) begin
      case (state_q)
        ST_INIT, ST_SWEEP: mem_we = 1'b1;
        ST_IDLE: begin
          ctl_ready = 1'b1;
          inv_busy  = 1'b0;
          mem_index = ctl_index;
          mem_wtag  = ctl_wtag;
          mem_we    = ctl_valid & ctl_we;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  assign ctl_rtag  = mem_rtag;
  assign dirty_cnt = dirty_cnt_q;
  assign inv_done  = inv_done_q;

  // NOTE: non-blocking assignments here so every flop updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      dirty_cnt_q <= '0;
      inv_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dirty_cnt_q <= dirty_cnt_d;
      inv_done_q  <= inv_done_d;
    end
  end

  a_done_in_idle: assert property (@(posedge clk) disable iff (rst)
    inv_done_q |-> (state_q == ST_IDLE));

  a_sweep_ends: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_SWEEP && last_entry) |=> (inv_done_q && state_q == ST_IDLE));

endmodule

// File: tb/tb_dm_cache_tag_ctrl.sv
// Directed bench for dm_cache_tag_ctrl with a behavioural 1024-entry tag store attached.
// Expected values are hand-derived from the intended port behaviour.
module tb_dm_cache_tag_ctrl;

  localparam int INDEX_W = 10;
  localparam int TAG_W   = 18;
  localparam int DEPTH   = 1 << INDEX_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               ctl_valid, ctl_we;
  logic [INDEX_W-1:0] ctl_index;
  logic [TAG_W+1:0]   ctl_wtag;
  logic               ctl_ready;
  logic [TAG_W+1:0]   ctl_rtag;
  logic               inv_req, inv_busy, inv_done;
  logic [INDEX_W:0]   dirty_cnt;
  logic               mem_we;
  logic [INDEX_W-1:0] mem_index;
  logic [TAG_W+1:0]   mem_wtag, mem_rtag;

  logic [TAG_W+1:0]   tag_mem [DEPTH];
  logic               mem_fill;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [19:0] TAG17 = 20'hEA5A5;  // {1,1,18'h2A5A5}
  localparam logic [19:0] V3    = 20'hD1234;  // valid+dirty
  localparam logic [19:0] W42   = 20'hF0042;  // valid+dirty

  always #5 clk = ~clk;

  dm_cache_tag_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .ctl_valid(ctl_valid), .ctl_we(ctl_we), .ctl_index(ctl_index), .ctl_wtag(ctl_wtag),
    .ctl_ready(ctl_ready), .ctl_rtag(ctl_rtag),
    .inv_req(inv_req), .inv_busy(inv_busy), .inv_done(inv_done), .dirty_cnt(dirty_cnt),
    .mem_we(mem_we), .mem_index(mem_index), .mem_wtag(mem_wtag), .mem_rtag(mem_rtag)
  );

  // Tag store: asynchronous read, write on the clock edge; optionally filled with non-zero junk.
  assign mem_rtag = tag_mem[mem_index];
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < DEPTH; i++) tag_mem[i] <= 20'hFFFFF ^ 20'(i);
    end else if (mem_we) begin
      tag_mem[mem_index] <= mem_wtag;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each sweep/init cycle: busy, not ready, clearing write at the stepping pointer, no done pulse.
  task automatic sweep_run(input string tag, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      #1;
      check(tag, {inv_busy, ctl_ready, mem_we, mem_index, mem_wtag, inv_done},
                 {1'b1, 1'b0, 1'b1, i[9:0], 20'h0, 1'b0});
      tick();
    end
  endtask

  task automatic idle_write(input int idx, input logic [19:0] val);
    ctl_valid = 1'b1; ctl_we = 1'b1; ctl_index = 10'(idx); ctl_wtag = val;
    tick();
    ctl_valid = 1'b0; ctl_we = 1'b0;
  endtask

  task automatic read_check(input string tag, input int idx, input logic [19:0] exp);
    ctl_valid = 1'b1; ctl_we = 1'b0; ctl_index = 10'(idx);
    #1;
    check(tag, {mem_we, ctl_rtag}, {1'b0, exp});
    tick();
    ctl_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mem_fill = 1'b1;
    ctl_valid = 1'b0; ctl_we = 1'b0; ctl_index = '0; ctl_wtag = '0; inv_req = 1'b0;
    tick();
    mem_fill = 1'b0;
    tick();
    #1;
    check("rst_out", {mem_we, ctl_ready, inv_busy}, 3'b001);
    check("rst_regs", {dirty_cnt, inv_done}, 12'h0);
    inv_req = 1'b1;  // must be ignored during INIT
    tick();
    rst = 1'b0;

    // 1. INIT clears 0..1023, then IDLE without inv_done
    sweep_run("init", 0, 1);
    inv_req = 1'b0;
    sweep_run("init", 1, DEPTH - 1);
    #1;
    check("idle_after_init", {ctl_ready, inv_busy, inv_done}, 3'b100);
    read_check("init_clr0", 0, 20'h0);
    read_check("init_clr511", 511, 20'h0);
    read_check("init_clr1023", 1023, 20'h0);

    // 2. zero-latency write then read of index 17
    ctl_valid = 1'b1; ctl_we = 1'b1; ctl_index = 10'd17; ctl_wtag = TAG17;
    #1;
    check("wr17", {mem_we, mem_index, mem_wtag, ctl_ready}, {1'b1, 10'd17, TAG17, 1'b1});
    tick();
    ctl_we = 1'b0;
    #1;
    check("rd17", {mem_we, ctl_rtag}, {1'b0, TAG17});
    tick();
    ctl_valid = 1'b0;

    // 3. five dirty, three clean, one dirty-but-invalid; single-cycle inv_req
    idle_write(0,    20'hC0001);
    idle_write(17,   20'hC0017);
    idle_write(300,  20'hC0300);
    idle_write(512,  20'hC0512);
    idle_write(1023, 20'hC1023);
    idle_write(5,    20'h80005);
    idle_write(600,  20'h80600);
    idle_write(1000, 20'h81000);
    idle_write(7,    20'h40007);
    inv_req = 1'b1;
    #1;
    check("inv_req_cycle", {ctl_ready, inv_busy}, 2'b10);
    tick();
    inv_req = 1'b0;
    sweep_run("sweep1", 0, DEPTH);
    #1;
    check("sweep1_done", {inv_done, dirty_cnt, ctl_ready, inv_busy}, {1'b1, 11'd5, 1'b1, 1'b0});
    tick();
    #1;
    check("sweep1_hold", {inv_done, dirty_cnt}, {1'b0, 11'd5});
    for (int i = 0; i < DEPTH; i++) read_check("sweep1_clr", i, 20'h0);

    // 4. client write held during a sweep retries and lands in IDLE
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    sweep_run("sweep2a", 0, 10);
    ctl_valid = 1'b1; ctl_we = 1'b1; ctl_index = 10'd3; ctl_wtag = V3;
    sweep_run("sweep2_blocked", 10, DEPTH - 10);
    #1;
    check("retry_lands", {inv_done, ctl_ready, mem_we, mem_index, mem_wtag, dirty_cnt},
                         {1'b1, 1'b1, 1'b1, 10'd3, V3, 11'd0});
    tick();
    ctl_valid = 1'b0; ctl_we = 1'b0;
    read_check("idx3", 3, V3);
    read_check("idx4", 4, 20'h0);

    // 5. reset at sweep cycle 500 with dirty_cnt=2
    idle_write(200, 20'hC0200);
    idle_write(800, 20'hC0800);
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    sweep_run("sweep3", 0, 500);
    #1;
    check("pre_rst", {dirty_cnt, mem_index}, {11'd2, 10'd500});
    rst = 1'b1;
    #1;
    check("rst_mid", {mem_we, ctl_ready, inv_busy}, 3'b001);
    tick();
    rst = 1'b0;
    #1;
    check("rst_regs2", {dirty_cnt, inv_done}, 12'h0);
    sweep_run("init2", 0, DEPTH);
    #1;
    check("idle_after_init2", {ctl_ready, inv_busy, inv_done, dirty_cnt}, {1'b1, 1'b0, 1'b0, 11'd0});
    read_check("idx800", 800, 20'h0);
    read_check("idx3_cleared", 3, 20'h0);

    // 6. inv_req held high: one IDLE cycle between sweeps, client write accepted there
    ctl_valid = 1'b1; ctl_we = 1'b1; ctl_index = 10'd42; ctl_wtag = W42;
    inv_req = 1'b1;
    #1;
    check("rep_start", {ctl_ready, mem_we, mem_index}, {1'b1, 1'b1, 10'd42});
    tick();
    for (int k = 0; k < 3; k++) begin
      sweep_run("rep_sweep", 0, DEPTH);
      #1;
      check("rep_gap", {inv_done, ctl_ready, inv_busy, mem_we, mem_index, mem_wtag, dirty_cnt},
                       {1'b1, 1'b1, 1'b0, 1'b1, 10'd42, W42, 11'd1});
      if (k == 2) inv_req = 1'b0;
      tick();
    end
    ctl_valid = 1'b0; ctl_we = 1'b0;
    #1;
    check("rep_stop", {ctl_ready, inv_busy, inv_done, dirty_cnt}, {1'b1, 1'b0, 1'b0, 11'd1});
    read_check("idx42", 42, W42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
